mole_game_ctrl: RTL and testbench

Game controller downstream of the round timer in the Whack-a-Mole design on Basys 3. It consumes the timer's 6-bit seconds-remaining value and drives the timer's reset. It runs the play loop: picks a pseudo-random hole, lights its mole LED for a bounded window, scores debounced button hits, and ends the round when time runs out. Its outputs feed the LED bank and the score display stage.

---
 rtl/mole_game_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mole_game_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_ctrl.sv
// Whack-a-Mole play-loop controller.
// Sequences gap/mole windows, picks a pseudo-random hole, scores button hits
// and ends the round when the armed round timer reaches zero.
// Handshake note: there is no valid/ready traffic here; start and btn are
// level inputs and only their rising edges (start_rise, btn_rise) act as events.
// The controller state is one cycle ahead of the registered outputs, which are
// loaded from it on every clock edge.
module mole_game_ctrl #(
  parameter int          MOLE_UP_CYCLES = 75_000_000,
  parameter int          GAP_CYCLES     = 25_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] time_left,
  input  logic [3:0] btn,
  output logic       timer_rst,
  output logic [3:0] mole,
  output logic [6:0] score,
  output logic [6:0] misses,
  output logic       playing,
  output logic       game_over,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] UP_LOAD  = 32'(MOLE_UP_CYCLES - 1);

  state_t      state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic [6:0]  score_i, score_nx;
  logic [6:0]  miss_i, miss_nx;
  logic        armed, armed_nx;
  logic [1:0]  hole, hole_nx;   // current (and therefore previous) hole
  logic [15:0] lfsr;
  logic        start_q;
  logic [3:0]  btn_q;

  logic        start_rise;
  logic [3:0]  btn_rise;
  logic [3:0]  hole_oh;
  logic [1:0]  pick;
  logic        end_cond;
  logic [6:0]  score_inc;
  logic [6:0]  miss_inc;

  assign dbg_state = state;

  // Edge detectors, free-running LFSR and controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      score_i <= '0;
      miss_i  <= '0;
      armed   <= 1'b0;
      hole    <= 2'd0;
      lfsr    <= LFSR_SEED;
      start_q <= 1'b0;
      btn_q   <= 4'b0000;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      score_i <= score_nx;
      miss_i  <= miss_nx;
      armed   <= armed_nx;
      hole    <= hole_nx;
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      start_q <= start;
      btn_q   <= btn;
    end
  end

  // Next-state logic: round sequencing, scoring and hole selection.
  always_comb begin
    start_rise = start & ~start_q;
    btn_rise   = btn & ~btn_q;
    hole_oh    = 4'b0001 << hole;
    pick       = lfsr[1:0];
    if (pick == hole) pick = pick + 2'd1;
    end_cond   = armed && (time_left == 6'd0);
    score_inc  = (score_i < 7'd99) ? score_i + 7'd1 : score_i;
    miss_inc   = (miss_i < 7'd99) ? miss_i + 7'd1 : miss_i;

    state_nx = state;
    cnt_nx   = cnt;
    score_nx = score_i;
    miss_nx  = miss_i;
    armed_nx = armed;
    hole_nx  = hole;

    // A non-zero timer value proves the timer has left its reset.
    if ((state == S_GAP || state == S_UP) && time_left != 6'd0) armed_nx = 1'b1;

    case (state)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          state_nx = S_GAP;
          cnt_nx   = GAP_LOAD;
          score_nx = '0;
          miss_nx  = '0;
          armed_nx = 1'b0;
        end
      end
      S_GAP: begin
        if (end_cond) begin
          state_nx = S_OVER;
        end else if (cnt == '0) begin
          state_nx = S_UP;
          cnt_nx   = UP_LOAD;
          hole_nx  = pick;
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      S_UP: begin
        if (end_cond) begin
          state_nx = S_OVER;
        end else if ((btn_rise & hole_oh) != 4'b0000) begin
          score_nx = score_inc;
          state_nx = S_GAP;
          cnt_nx   = GAP_LOAD;
        end else if (btn_rise != 4'b0000) begin
          // Wrong press keeps the mole up; the window keeps running but
          // never underflows so expiry still fires on a later cycle.
          miss_nx = miss_inc;
          if (cnt != '0) cnt_nx = cnt - 32'd1;
        end else if (cnt == '0) begin
          miss_nx  = miss_inc;
          state_nx = S_GAP;
          cnt_nx   = GAP_LOAD;
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the controller state.
  always_ff @(posedge clk) begin
    if (rst) begin
      mole      <= 4'b0000;
      score     <= '0;
      misses    <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      timer_rst <= 1'b1;
    end else begin
      mole      <= (state == S_UP) ? hole_oh : 4'b0000;
      score     <= score_i;
      misses    <= miss_i;
      playing   <= (state == S_GAP) || (state == S_UP);
      game_over <= (state == S_OVER);
      timer_rst <= (state == S_IDLE) || (state == S_OVER);
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl with a rule-level game model.
module tb_mole_game_ctrl;
  localparam int          UP_C  = 8;
  localparam int          GAP_C = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [20:0] RST_W = {1'b1, 4'b0000, 7'd0, 7'd0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] time_left = 6'd0;
  logic [3:0] btn = 4'b0000;
  logic       timer_rst;
  logic [3:0] mole;
  logic [6:0] score, misses;
  logic       playing, game_over;
  logic [1:0] dbg_state;

  mole_game_ctrl #(
    .MOLE_UP_CYCLES(UP_C),
    .GAP_CYCLES    (GAP_C),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .time_left(time_left),
    .btn      (btn),
    .timer_rst(timer_rst),
    .mole     (mole),
    .score    (score),
    .misses   (misses),
    .playing  (playing),
    .game_over(game_over),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Rule-level model: phase 0 idle, 1 gap, 2 mole up, 3 over;
  // m_left counts remaining cycles of the current gap or mole window.
  int          m_phase, m_left, m_score, m_miss;
  bit          m_armed;
  logic [1:0]  m_hole;
  logic [15:0] m_lfsr;
  logic        m_start_q;
  logic [3:0]  m_btn_q;
  logic [20:0] exp_q[$];
  logic [20:0] exp_w = '0;
  logic [20:0] dut_w;
  assign dut_w = {timer_rst, mole, score, misses, playing, game_over};

  task automatic model_step();
    logic [20:0] w;
    logic [3:0]  rise;
    logic [1:0]  h;
    if (rst) begin
      w = RST_W;
      m_phase = 0; m_left = 0; m_score = 0; m_miss = 0; m_armed = 0;
      m_hole = 2'd0; m_lfsr = SEED; m_start_q = 1'b0; m_btn_q = 4'b0000;
    end else begin
      w = {(m_phase == 0 || m_phase == 3),
           (m_phase == 2) ? (4'b0001 << m_hole) : 4'b0000,
           7'(m_score), 7'(m_miss),
           (m_phase == 1 || m_phase == 2), (m_phase == 3)};
      rise = btn & ~m_btn_q;
      case (m_phase)
        0, 3: if (start && !m_start_q) begin
          m_phase = 1; m_left = GAP_C; m_score = 0; m_miss = 0; m_armed = 0;
        end
        1: if (m_armed && time_left == 6'd0) m_phase = 3;
        else begin
          if (time_left != 6'd0) m_armed = 1;
          m_left = m_left - 1;
          if (m_left == 0) begin
            h = m_lfsr[1:0];
            if (h == m_hole) h = h + 2'd1;
            m_hole = h; m_phase = 2; m_left = UP_C;
          end
        end
        default: if (m_armed && time_left == 6'd0) m_phase = 3;
        else begin
          if (time_left != 6'd0) m_armed = 1;
          if ((rise & (4'b0001 << m_hole)) != 4'b0000) begin
            if (m_score < 99) m_score = m_score + 1;
            m_phase = 1; m_left = GAP_C;
          end else if (rise != 4'b0000) begin
            if (m_miss < 99) m_miss = m_miss + 1;
            if (m_left > 1) m_left = m_left - 1;
          end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
              if (m_miss < 99) m_miss = m_miss + 1;
              m_phase = 1; m_left = GAP_C;
            end
          end
        end
      endcase
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_start_q = start;
      m_btn_q = btn;
    end
    exp_q.push_back(w);
  endtask

  // driver: one clock; the model sees the same inputs as the DUT at the edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (exp_q.size() > 0) exp_w = exp_q.pop_front();
  endtask

  task automatic wait_new_mole(input int budget);
    int n = 0;
    while (mole != 4'b0000 && n < budget) begin tick(); n++; end
    while (mole == 4'b0000 && n < budget) begin tick(); n++; end
    n_cmp++;
    if (mole == 4'b0000) begin
      n_fail++; $display("FAIL wait_mole: mole=%b after %0d cycles, required nonzero", mole, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; btn = 4'b0000; time_left = 6'd0;
    repeat (3) tick();
    n_cmp++; if (dut_w !== RST_W) begin n_fail++; $display("FAIL reset_word: got %h want %h", dut_w, RST_W); end
    n_cmp++; if (timer_rst !== 1'b1) begin n_fail++; $display("FAIL reset_timer_rst: got %b want 1", timer_rst); end
    n_cmp++; if (mole !== 4'b0000 || playing !== 1'b0 || game_over !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: mole=%b playing=%b game_over=%b want 0/0/0", mole, playing, game_over);
    end
    n_cmp++; if (score !== 7'd0 || misses !== 7'd0) begin
      n_fail++; $display("FAIL reset_counts: score=%0d misses=%0d want 0/0", score, misses);
    end
  endtask

  task automatic test_idle();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_cmp++;
      if (mole !== 4'b0000 || timer_rst !== 1'b1 || playing !== 1'b0) begin
        n_fail++; $display("FAIL idle: mole=%b timer_rst=%b playing=%b want 0000/1/0", mole, timer_rst, playing);
      end
    end
    n_cmp++; if (dut_w !== exp_w) begin n_fail++; $display("FAIL idle_model: got %h want %h", dut_w, exp_w); end
  endtask

  task automatic test_hit();
    logic [3:0] m;
    time_left = 6'd60; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (playing !== 1'b0) begin n_fail++; $display("FAIL hit_early_playing: got %b want 0", playing); end
    tick();
    n_cmp++; if (playing !== 1'b1 || timer_rst !== 1'b0) begin
      n_fail++; $display("FAIL hit_playing: playing=%b timer_rst=%b want 1/0", playing, timer_rst);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (mole !== 4'b0000) begin n_fail++; $display("FAIL hit_gap1: mole=%b want 0000", mole); end
    end
    tick();
    n_cmp++; if (!$onehot(mole)) begin n_fail++; $display("FAIL hit_first_mole: mole=%b want one-hot", mole); end
    n_cmp++; if (dut_w !== exp_w) begin n_fail++; $display("FAIL hit_first_model: got %h want %h", dut_w, exp_w); end
    m = mole;
    tick(); tick();
    n_cmp++; if (mole !== m) begin n_fail++; $display("FAIL hit_lit3: mole=%b want %b", mole, m); end
    btn = m;
    tick();
    btn = 4'b0000;
    n_cmp++; if (mole !== m || score !== 7'd0) begin
      n_fail++; $display("FAIL hit_latency: mole=%b score=%0d want %b/0", mole, score, m);
    end
    tick();
    n_cmp++; if (score !== 7'd1 || mole !== 4'b0000) begin
      n_fail++; $display("FAIL hit_score: score=%0d mole=%b want 1/0000", score, mole);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (mole !== 4'b0000) begin n_fail++; $display("FAIL hit_gap2: mole=%b want 0000", mole); end
    end
    tick();
    n_cmp++; if (!$onehot(mole)) begin n_fail++; $display("FAIL hit_next_mole: mole=%b want one-hot", mole); end
    n_cmp++; if (dut_w !== exp_w) begin n_fail++; $display("FAIL hit_next_model: got %h want %h", dut_w, exp_w); end
  endtask

  task automatic test_wrong_and_expiry();
    logic [3:0] m, wrong;
    logic [6:0] base;
    wait_new_mole(40);
    m = mole; base = misses;
    wrong = 4'($urandom_range(1, 15));
    while ((wrong & m) != 4'b0000 || wrong == 4'b0000) wrong = 4'($urandom_range(1, 15));
    btn = wrong;
    tick();
    btn = 4'b0000;
    tick();
    n_cmp++; if (misses !== base + 7'd1 || mole !== m) begin
      n_fail++; $display("FAIL wrong_press: misses=%0d mole=%b want %0d/%b", misses, mole, base + 7'd1, m);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (mole !== m) begin n_fail++; $display("FAIL expiry_lit: mole=%b want %b", mole, m); end
    end
    tick();
    n_cmp++; if (mole !== 4'b0000 || misses !== base + 7'd2) begin
      n_fail++; $display("FAIL expiry: mole=%b misses=%0d want 0000/%0d", mole, misses, base + 7'd2);
    end
    n_cmp++; if (dut_w !== exp_w) begin n_fail++; $display("FAIL expiry_model: got %h want %h", dut_w, exp_w); end
  endtask

  task automatic test_race();
    logic [3:0] m;
    logic [6:0] bs, bm;
    wait_new_mole(40);
    m = mole; bs = score; bm = misses;
    btn = m | {m[2:0], m[3]};
    tick();
    btn = 4'b0000;
    tick();
    n_cmp++; if (score !== bs + 7'd1 || misses !== bm || mole !== 4'b0000) begin
      n_fail++; $display("FAIL race: score=%0d misses=%0d mole=%b want %0d/%0d/0000", score, misses, mole, bs + 7'd1, bm);
    end
  endtask

  task automatic test_end_of_round();
    logic [3:0] m;
    logic [6:0] bs;
    wait_new_mole(40);
    m = mole; bs = score;
    time_left = 6'd0; btn = m;
    tick();
    btn = 4'b0000;
    tick();
    n_cmp++; if (game_over !== 1'b1 || mole !== 4'b0000 || timer_rst !== 1'b1 || playing !== 1'b0) begin
      n_fail++; $display("FAIL end_flags: go=%b mole=%b trst=%b play=%b want 1/0000/1/0", game_over, mole, timer_rst, playing);
    end
    n_cmp++; if (score !== bs) begin n_fail++; $display("FAIL end_score: score=%0d want %0d", score, bs); end
    tick(); tick();
    n_cmp++; if (dut_w !== exp_w) begin n_fail++; $display("FAIL end_hold_model: got %h want %h", dut_w, exp_w); end
    time_left = 6'd60; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (score !== 7'd0 || misses !== 7'd0 || playing !== 1'b1 || game_over !== 1'b0) begin
      n_fail++; $display("FAIL restart: score=%0d misses=%0d play=%b go=%b want 0/0/1/0", score, misses, playing, game_over);
    end
  endtask

  task automatic test_stale_zero();
    time_left = 6'd0;
    tick(); tick();
    n_cmp++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL stale_pre_end: go=%b want 1", game_over); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i > 0) begin
        n_cmp++; if (playing !== 1'b1 || game_over !== 1'b0) begin
          n_fail++; $display("FAIL stale_hold: play=%b go=%b want 1/0", playing, game_over);
        end
      end
    end
    time_left = 6'd5;
    tick();
    time_left = 6'd0;
    tick();
    n_cmp++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL stale_latency: go=%b want 0", game_over); end
    tick();
    n_cmp++; if (game_over !== 1'b1 || playing !== 1'b0) begin
      n_fail++; $display("FAIL stale_end: go=%b play=%b want 1/0", game_over, playing);
    end
  endtask

  task automatic test_saturation();
    time_left = 6'd60; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 105; i++) begin
      wait_new_mole(40);
      n_cmp++; if (score !== 7'((i < 99) ? i : 99)) begin
        n_fail++; $display("FAIL sat_progress: score=%0d want %0d", score, (i < 99) ? i : 99);
      end
      btn = mole;
      tick();
      btn = 4'b0000;
    end
    tick(); tick();
    n_cmp++; if (score !== 7'd99 || misses !== 7'd0) begin
      n_fail++; $display("FAIL sat_final: score=%0d misses=%0d want 99/0", score, misses);
    end
    n_cmp++; if (dut_w !== exp_w) begin n_fail++; $display("FAIL sat_model: got %h want %h", dut_w, exp_w); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    n_cmp++; if (dut_w !== RST_W) begin n_fail++; $display("FAIL reset_mid: got %h want %h", dut_w, RST_W); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 11) == 0) start = ~start;
      btn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if ($urandom_range(0, 9) == 0)
        time_left = ($urandom_range(0, 99) < 30) ? 6'd0 : 6'($urandom_range(1, 63));
      tick();
      n_cmp++; if (dut_w !== exp_w) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_w, exp_w);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_hit();
    test_wrong_and_expiry();
    test_race();
    test_end_of_round();
    test_stale_zero();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
